// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end for the SPI RAM datapath.
// Deserializes 10-bit command words from MOSI (MSB first) and presents each
// completed word on rx_data with a one-cycle rx_valid strobe. For read-data
// frames it waits for tx_valid and then serializes tx_data on MISO.
// The internal rd_addr_seen flag makes consecutive read frames alternate
// between read-address and read-data sequencing.
// Optional feature: define SPI_SLAVE_ABORT_FLAG_EN to add the frame_abort
// output, a one-cycle pulse after SS_n ends an incomplete frame.
module spi_slave_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  ,
  output logic       frame_abort
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // bit_cnt counts the 9 bits after the command bit; WORD_DONE marks a full word
  localparam logic [3:0] LAST_BIT  = 4'd8;
  localparam logic [3:0] WORD_DONE = 4'd9;
  localparam logic [3:0] TX_BITS   = 4'd8;

  state_t      state;
  state_t      next_state;
  logic [3:0]  bit_cnt;
  logic [8:0]  rx_sr;
  logic [7:0]  tx_sr;
  logic [3:0]  tx_cnt;
  logic        tx_busy;
  logic        tx_done;
  logic        rd_addr_seen;

  logic        in_frame;
  logic        frame_exit;
  logic        shift_en;
  logic        cnt_en;
  logic        word_done;
  logic        tx_load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: SS_n high always returns to IDLE; bit 9 picks the branch
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)               next_state = IDLE;
        else if (!MOSI)         next_state = WRITE;
        else if (!rd_addr_seen) next_state = READ_ADD;
        else                    next_state = READ_DATA;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/control decode: shift enables, word completion and tx handshake
  always_comb begin
    in_frame   = 1'b0;
    frame_exit = 1'b0;
    shift_en   = 1'b0;
    cnt_en     = 1'b0;
    word_done  = 1'b0;
    tx_load    = 1'b0;
    in_frame   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    frame_exit = SS_n && (state != IDLE);
    cnt_en     = !SS_n && in_frame && (bit_cnt != WORD_DONE);
    shift_en   = (!SS_n && (state == CHK_CMD)) || cnt_en;
    word_done  = !SS_n && in_frame && (bit_cnt == LAST_BIT);
    // tx_valid only matters in the wait window between word completion and load
    tx_load    = !SS_n && (state == READ_DATA) && (bit_cnt == WORD_DONE) &&
                 !tx_busy && !tx_done && tx_valid;
  end

  // Datapath: receive shifter, rx word/strobe, read flag and MISO serializer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_sr        <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (frame_exit) begin
        // Partial frames leave rx_data and rd_addr_seen untouched
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
        tx_cnt  <= '0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
        MISO    <= 1'b0;
      end else begin
        if (shift_en) rx_sr   <= {rx_sr[7:0], MOSI};
        if (cnt_en)   bit_cnt <= bit_cnt + 4'd1;
        if (word_done) begin
          rx_data <= {rx_sr, MOSI};
          if (state == READ_ADD)       rd_addr_seen <= 1'b1;
          else if (state == READ_DATA) rd_addr_seen <= 1'b0;
        end
        if (tx_load) begin
          MISO    <= tx_data[7];
          tx_sr   <= {tx_data[6:0], 1'b0};
          tx_cnt  <= 4'd1;
          tx_busy <= 1'b1;
        end else if (tx_busy) begin
          if (tx_cnt == TX_BITS) begin
            MISO    <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            MISO   <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b0};
            tx_cnt <= tx_cnt + 4'd1;
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic abort_det;

  // A frame is incomplete if the word is short or a read-data reply is unfinished
  always_comb begin
    abort_det = frame_exit &&
                ((bit_cnt != WORD_DONE) || ((state == READ_DATA) && !tx_done));
  end

  // Abort flag register: one-cycle pulse after the aborting SS_n sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_abort <= 1'b0;
    else        frame_abort <= abort_det;
  end
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed bench for spi_slave_ctrl. Each frame is driven
// cycle by cycle from the cycle SS_n is first low (cycle 0); outputs are
// sampled on the falling edge and compared against hand-computed values.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic       frame_abort;
`endif

  int         n_vec;
  int         n_mis;
  logic [9:0] exp_rx;

  spi_slave_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    ,
    .frame_abort (frame_abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // w: word; nbits: bits shifted before SS_n rises (10 = full frame)
  // tx_n: cycle tx_valid is driven (0 = never); resp: MISO reply expected
  // abort_exp: expected frame_abort after the frame; gap: idle cycles after
  // rst_cyc: cycle in which reset is asserted mid-frame (-1 = none)
  task automatic frame(input logic [9:0] w, input int nbits, input int tx_n,
                       input logic [7:0] tb, input bit resp, input bit abort_exp,
                       input int gap, input int rst_cyc);
    int   len;
    bit   full;
    logic exp_miso;
    full = (nbits == 10);
    if (!full)                       len = nbits + 1;
    else if (tx_n > 0 && tx_n > 3)   len = tx_n + 9;
    else                             len = 12;
    for (int c = 0; c <= len; c++) begin
      SS_n     = (c == len);
      MOSI     = (c >= 1 && c <= nbits) ? w[10-c] : 1'b0;
      tx_valid = (tx_n > 0 && c == tx_n);
      tx_data  = tb;
      @(negedge clk);
      exp_miso = (resp && tx_n > 0 && c > tx_n && c <= tx_n + 8) ? tb[7-(c-tx_n-1)] : 1'b0;
      chk("miso", MISO, exp_miso);
      chk("rx_valid", rx_valid, full && c == 11);
      if (full && c == 11) begin
        exp_rx = w;
        chk("rx_data", rx_data, exp_rx);
      end
      if (c == len) chk("rx_data_hold", rx_data, exp_rx);
      if (c == rst_cyc) begin
        #2 rst_n = 1'b0;
        #1;
        chk("miso_rst", MISO, 1'b0);
        chk("rx_valid_rst", rx_valid, 1'b0);
        chk("rx_data_rst", rx_data, 10'h000);
        exp_rx = 10'h000;
        tx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    MOSI     = 1'b0;
    if (gap >= 2) begin
      SS_n = 1'b1;
      @(negedge clk);
      chk("miso_idle", MISO, 1'b0);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      chk("frame_abort", frame_abort, abort_exp);
`endif
      @(posedge clk);
      #1;
      for (int g = 2; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_mis    = 0;
    exp_rx   = 10'h000;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miso", MISO, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 10'h000);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    chk("rst_frame_abort", frame_abort, 1'b0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // write address then write data, back-to-back; tx_valid must be ignored
    frame(10'h0A5, 10, 11, 8'hFF, 1'b0, 1'b0, 1, -1);
    frame(10'h13C, 10, 11, 8'hFF, 1'b0, 1'b0, 2, -1);

    // read address (no reply) then read data with immediate tx_valid
    frame(10'h2A5, 10, 11, 8'hFF, 1'b0, 1'b0, 2, -1);
    frame(10'h300, 10, 11, 8'h5C, 1'b1, 1'b0, 2, -1);

    // rd_addr_seen was cleared, so the next read is an address frame again
    frame(10'h2A5, 10, 11, 8'h33, 1'b0, 1'b0, 2, -1);
    frame(10'h300, 10, 15, 8'h5C, 1'b1, 1'b0, 2, -1);

    // abort after 5 bits: no strobe, rx_data keeps 0x300
    frame(10'h1FF, 5, 0, 8'h00, 1'b0, 1'b1, 2, -1);

    // a write between read address and read data keeps rd_addr_seen
    frame(10'h2A5, 10, 11, 8'hFF, 1'b0, 1'b0, 2, -1);
    frame(10'h0FF, 10, 11, 8'hFF, 1'b0, 1'b0, 2, -1);
    frame(10'h3C3, 10, 11, 8'hA6, 1'b1, 1'b0, 2, -1);

    // reset during MISO bit 3 (cycle 16), then reads restart from address
    frame(10'h2A5, 10, 11, 8'hFF, 1'b0, 1'b0, 2, -1);
    frame(10'h35A, 10, 11, 8'h5C, 1'b1, 1'b0, 2, 16);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    SS_n  = 1'b1;
    @(posedge clk);
    #1;
    frame(10'h3F0, 10, 11, 8'hFF, 1'b0, 1'b0, 2, -1);
    frame(10'h301, 10, 11, 8'h81, 1'b1, 1'b0, 2, -1);

    // SS_n rises while still waiting for tx_valid in read data
    frame(10'h2A5, 10, 11, 8'hFF, 1'b0, 1'b0, 2, -1);
    frame(10'h3AA, 10, 0, 8'h00, 1'b0, 1'b1, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
